// File: rtl/lc3_datapath.sv
// lc3_datapath
// ---------------------------------------------------------------------------
// LC-3 datapath slaved to the LC-3 control unit. Each cycle it applies the
// control word it is given. It holds PC, IR, MAR, MDR, the N/Z/P condition
// codes and an 8x16 register file. It also contains the ALU, the effective
// address block (EAB) and the single internal 16-bit bus. Memory is external:
// reads are combinational from mem_addr and writes commit at the rising edge.
//
// Ports
//   clk, reset         rising-edge clock; synchronous active-low reset
//   aluControl         00 ADD, 01 AND, 10 NOT A, 11 PASS A
//   enaPC/enaMDR/enaALU/enaMARM
//                      bus drive enables; priority is PC > MDR > ALU > MARMUX
//   selMAR             MARMUX: 0 = zext(IR[7:0]), 1 = EAB
//   selEAB1, selEAB2   EAB operand selects (ADDR1 / ADDR2)
//   ldPC/ldIR/ldMAR/ldMDR
//                      register load enables
//   selPC              00 PC+1, 01 EAB, 10 bus, 11 hold
//   selMDR             0 = bus, 1 = mem_rdata
//   SR1, SR2, DR       register-file read A, read B and write indices
//   regWE              register-file write; also loads N/Z/P
//   memWE              memory write strobe, passed straight to mem_we
//   mem_rdata          combinational memory read data
//   IR, N, Z, P        returned to the control unit
//   mem_addr/mem_wdata registered MAR / MDR
//   pc_out, bus_out    debug observation of PC and the bus
// ---------------------------------------------------------------------------
module lc3_datapath #(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  aluControl,
    input  logic        enaALU,
    input  logic        enaMARM,
    input  logic        enaMDR,
    input  logic        enaPC,
    input  logic        selMAR,
    input  logic        selEAB1,
    input  logic [1:0]  selEAB2,
    input  logic        ldPC,
    input  logic        ldIR,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic [1:0]  selPC,
    input  logic        selMDR,
    input  logic [2:0]  SR1,
    input  logic [2:0]  SR2,
    input  logic [2:0]  DR,
    input  logic        regWE,
    input  logic        memWE,
    input  logic [15:0] mem_rdata,
    output logic [15:0] IR,
    output logic        N,
    output logic        Z,
    output logic        P,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic [15:0] pc_out,
    output logic [15:0] bus_out
);

    // Architectural state
    logic [15:0] pc_q,  pc_d;
    logic [15:0] ir_q,  ir_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        n_q, z_q, p_q;
    logic        n_d, z_d, p_d;
    logic [15:0] rf_q [8];
    logic [15:0] rf_d [8];

    // Combinational datapath nets
    logic [15:0] bus;
    logic [15:0] rf_a;
    logic [15:0] rf_b;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [15:0] eab;
    logic [15:0] marmux;

    // Register-file read ports are purely combinational on the current
    // contents, so a read of DR during its own write cycle sees the old value.
    assign rf_a = rf_q[SR1];
    assign rf_b = rf_q[SR2];

    // ALU: IR[5] chooses the sign-extended imm5 over the second register.
    always_comb begin
        alu_b   = ir_q[5] ? {{11{ir_q[4]}}, ir_q[4:0]} : rf_b;
        alu_out = 16'h0000;
        case (aluControl)
            2'b00:   alu_out = rf_a + alu_b;
            2'b01:   alu_out = rf_a & alu_b;
            2'b10:   alu_out = ~rf_a;
            default: alu_out = rf_a;
        endcase
    end

    // Effective address block and MARMUX
    always_comb begin
        addr1 = selEAB1 ? rf_a : pc_q;
        addr2 = 16'h0000;
        case (selEAB2)
            2'b00:   addr2 = 16'h0000;
            2'b01:   addr2 = {{10{ir_q[5]}},  ir_q[5:0]};
            2'b10:   addr2 = {{7{ir_q[8]}},   ir_q[8:0]};
            default: addr2 = {{5{ir_q[10]}},  ir_q[10:0]};
        endcase
        eab    = addr1 + addr2;
        marmux = selMAR ? eab : {8'h00, ir_q[7:0]};
    end

    // Single shared bus. Several enables may be asserted together; the
    // fixed priority decides the driver, and an idle bus reads as zero.
    always_comb begin
        if (enaPC)
            bus = pc_q;
        else if (enaMDR)
            bus = mdr_q;
        else if (enaALU)
            bus = alu_out;
        else if (enaMARM)
            bus = marmux;
        else
            bus = 16'h0000;
    end

    // Next-state for PC / IR / MAR / MDR / condition codes. Every load
    // samples pre-edge values, so simultaneous loads never interact.
    always_comb begin
        pc_d = pc_q;
        if (ldPC) begin
            case (selPC)
                2'b00:   pc_d = pc_q + 16'h0001;
                2'b01:   pc_d = eab;
                2'b10:   pc_d = bus;
                default: pc_d = pc_q;
            endcase
        end

        ir_d  = ldIR  ? bus : ir_q;
        mar_d = ldMAR ? bus : mar_q;
        mdr_d = ldMDR ? (selMDR ? mem_rdata : bus) : mdr_q;

        n_d = n_q;
        z_d = z_q;
        p_d = p_q;
        if (regWE) begin
            n_d = bus[15];
            z_d = (bus == 16'h0000);
            p_d = ~bus[15] & (bus != 16'h0000);
        end
    end

    // Register-file write decode, one row per entry.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rf_next
            assign rf_d[gi] = (regWE && (DR == 3'(gi))) ? bus : rf_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= 16'h0000;
            mar_q <= 16'h0000;
            mdr_q <= 16'h0000;
            n_q   <= 1'b0;
            z_q   <= 1'b1;
            p_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            n_q   <= n_d;
            z_q   <= z_d;
            p_q   <= p_d;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Outputs
    assign IR        = ir_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign P         = p_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mem_we    = memWE;
    assign pc_out    = pc_q;
    assign bus_out   = bus;

endmodule

// File: tb/tb_lc3_datapath.sv
// Self-checking bench for lc3_datapath. The stimulus process drives the
// control word and pushes hand-computed expectations, each tagged with the
// cycle it applies to. A separate monitor samples the DUT on the falling edge
// and retires the matching entries.
module tb_lc3_datapath;

    logic        clk;
    logic        reset;
    logic [1:0]  aluControl;
    logic        enaALU, enaMARM, enaMDR, enaPC;
    logic        selMAR, selEAB1;
    logic [1:0]  selEAB2;
    logic        ldPC, ldIR, ldMAR, ldMDR;
    logic [1:0]  selPC;
    logic        selMDR;
    logic [2:0]  SR1, SR2, DR;
    logic        regWE, memWE;
    logic [15:0] mem_rdata;
    logic [15:0] IR;
    logic        N, Z, P;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [15:0] pc_out, bus_out;

    lc3_datapath #(.RESET_PC(16'h3000)) dut (
        .clk(clk), .reset(reset), .aluControl(aluControl),
        .enaALU(enaALU), .enaMARM(enaMARM), .enaMDR(enaMDR), .enaPC(enaPC),
        .selMAR(selMAR), .selEAB1(selEAB1), .selEAB2(selEAB2),
        .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .selPC(selPC), .selMDR(selMDR), .SR1(SR1), .SR2(SR2), .DR(DR),
        .regWE(regWE), .memWE(memWE), .mem_rdata(mem_rdata),
        .IR(IR), .N(N), .Z(Z), .P(P), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .pc_out(pc_out),
        .bus_out(bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Memory model with a backdoor preload port
    logic [15:0] mem [0:65535];
    logic        bd_we;
    logic [15:0] bd_addr, bd_data;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (bd_we)  mem[bd_addr]  <= bd_data;
    end

    // Scoreboard
    localparam int S_PC = 0, S_IR = 1, S_MAR = 2, S_MDR = 3, S_NZP = 4,
                   S_BUS = 5, S_MEM = 6, S_WE = 7;
    typedef struct {
        int          cyc;
        int          sel;
        int          idx;
        logic [15:0] exp;
    } exp_t;
    exp_t  sb[$];
    string sb_name[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic sb_push(input int sel, input int idx, input logic [15:0] exp, input string name);
        exp_t e;
        e.cyc = cycle_cnt;
        e.sel = sel;
        e.idx = idx;
        e.exp = exp;
        sb.push_back(e);
        sb_name.push_back(name);
    endtask

    function automatic logic [15:0] observe(input int sel, input int idx);
        case (sel)
            S_PC:    return pc_out;
            S_IR:    return IR;
            S_MAR:   return mem_addr;
            S_MDR:   return mem_wdata;
            S_NZP:   return {13'h0, N, Z, P};
            S_BUS:   return bus_out;
            S_MEM:   return mem[idx[15:0]];
            default: return {15'h0, mem_we};
        endcase
    endfunction

    exp_t        mon_e;
    string       mon_n;
    logic [15:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cycle_cnt) begin
            mon_e   = sb.pop_front();
            mon_n   = sb_name.pop_front();
            mon_act = observe(mon_e.sel, mon_e.idx);
            checks++;
            if (mon_e.cyc != cycle_cnt || mon_act !== mon_e.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         mon_n, mon_act, mon_e.exp, cycle_cnt, mon_e.cyc);
            end
        end
    end

    // Stimulus helpers
    task automatic clear_ctrl();
        aluControl = 2'b00; enaALU = 0; enaMARM = 0; enaMDR = 0; enaPC = 0;
        selMAR = 0; selEAB1 = 0; selEAB2 = 2'b00; ldPC = 0; ldIR = 0;
        ldMAR = 0; ldMDR = 0; selPC = 2'b00; selMDR = 0;
        SR1 = 3'd0; SR2 = 3'd0; DR = 3'd0; regWE = 0; memWE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    task automatic rd_reg(input logic [2:0] r, input logic [15:0] exp);
        SR1 = r; aluControl = 2'b11; enaALU = 1;
        sb_push(S_BUS, 0, exp, $sformatf("read_R%0d", r));
        tick();
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] instr);
        enaPC = 1; ldMAR = 1; ldPC = 1; selPC = 2'b00;
        sb_push(S_BUS, 0, pc, "fetch_bus_pc");
        tick();
        sb_push(S_MAR, 0, pc, "fetch_mar");
        sb_push(S_PC, 0, pc + 16'h1, "fetch_pc_inc");
        ldMDR = 1; selMDR = 1;
        tick();
        sb_push(S_MDR, 0, instr, "fetch_mdr");
        enaMDR = 1; ldIR = 1;
        tick();
        sb_push(S_IR, 0, instr, "fetch_ir");
    endtask

    // Memory preload table
    logic [15:0] pre_addr [10];
    logic [15:0] pre_data [10];

    initial begin
        pre_addr[0] = 16'h3000; pre_data[0] = 16'h1261;
        pre_addr[1] = 16'h3001; pre_data[1] = 16'h5260;
        pre_addr[2] = 16'h3002; pre_data[2] = 16'h0FFE;
        pre_addr[3] = 16'h0000; pre_data[3] = 16'h4000;
        pre_addr[4] = 16'h0001; pre_data[4] = 16'h5000;
        pre_addr[5] = 16'h0002; pre_data[5] = 16'hABCD;
        pre_addr[6] = 16'h0003; pre_data[6] = 16'h14A1;
        pre_addr[7] = 16'h0004; pre_data[7] = 16'h0007;
        pre_addr[8] = 16'h4000; pre_data[8] = 16'h1111;
        pre_addr[9] = 16'h5000; pre_data[9] = 16'h2222;

        clear_ctrl();
        reset = 0; bd_we = 0; bd_addr = 16'h0; bd_data = 16'h0;

        // Reset held while loads are requested; reset must win.
        for (int i = 0; i < 10; i++) begin
            ldPC = 1; selPC = 2'b10; enaALU = 1; aluControl = 2'b10;
            ldIR = 1; ldMAR = 1; ldMDR = 1; regWE = 1; DR = 3'(i);
            bd_we = 1; bd_addr = pre_addr[i]; bd_data = pre_data[i];
            tick();
        end
        bd_we = 0;
        reset = 1;
        sb_push(S_PC,  0, 16'h3000, "reset_pc");
        sb_push(S_IR,  0, 16'h0000, "reset_ir");
        sb_push(S_MAR, 0, 16'h0000, "reset_mar");
        sb_push(S_MDR, 0, 16'h0000, "reset_mdr");
        sb_push(S_NZP, 0, 16'h0002, "reset_nzp");
        tick();
        for (int r = 0; r < 8; r++) rd_reg(3'(r), 16'h0000);

        // Fetch from 3000
        fetch(16'h3000, 16'h1261);

        // Bus priority
        enaPC = 1; enaALU = 1; aluControl = 2'b11;
        sb_push(S_BUS, 0, 16'h3001, "prio_pc_over_alu");
        tick();
        enaMDR = 1; enaALU = 1; aluControl = 2'b10; enaMARM = 1;
        sb_push(S_BUS, 0, 16'h1261, "prio_mdr_over_alu");
        tick();
        enaALU = 1; aluControl = 2'b10; enaMARM = 1;
        sb_push(S_BUS, 0, 16'hFFFF, "prio_alu_over_marm");
        tick();
        enaMARM = 1; selMAR = 0;
        sb_push(S_BUS, 0, 16'h0061, "marmux_zext");
        tick();
        sb_push(S_BUS, 0, 16'h0000, "bus_idle");
        tick();

        // ALU and condition codes, IR=1261 gives imm5 = +1
        SR1 = 3'd0; DR = 3'd3; enaALU = 1; regWE = 1;
        sb_push(S_BUS, 0, 16'h0001, "r3_add_imm");
        tick();
        sb_push(S_NZP, 0, 16'h0001, "nzp_pos_r3");
        for (int i = 0; i < 5; i++) begin
            SR1 = 3'd1; DR = 3'd1; enaALU = 1; regWE = 1;
            sb_push(S_BUS, 0, 16'(i + 1), "r1_preload");
            tick();
        end
        SR1 = 3'd1; DR = 3'd1; enaALU = 1; regWE = 1;
        sb_push(S_BUS, 0, 16'h0006, "add_r1");
        tick();
        sb_push(S_NZP, 0, 16'h0001, "add_nzp_p");
        rd_reg(3'd1, 16'h0006);
        SR1 = 3'd1; DR = 3'd1; aluControl = 2'b10; enaALU = 1; regWE = 1;
        sb_push(S_BUS, 0, 16'hFFF9, "not_r1");
        tick();
        sb_push(S_NZP, 0, 16'h0004, "not_nzp_n");

        // AND R1,R1,#0
        fetch(16'h3001, 16'h5260);
        SR1 = 3'd1; DR = 3'd1; aluControl = 2'b01; enaALU = 1; regWE = 1;
        sb_push(S_BUS, 0, 16'h0000, "and_imm0");
        tick();
        sb_push(S_NZP, 0, 16'h0002, "and_nzp_z");
        rd_reg(3'd1, 16'h0000);

        // Branch / EAB wrap, IR[8:0]=1FE
        fetch(16'h3002, 16'h0FFE);
        ldPC = 1; selPC = 2'b01; selEAB1 = 1; SR1 = 3'd3; selEAB2 = 2'b00;
        enaMARM = 1; selMAR = 1;
        sb_push(S_BUS, 0, 16'h0001, "eab_rf_plus0");
        tick();
        sb_push(S_PC, 0, 16'h0001, "pc_from_eab");
        ldPC = 1; selPC = 2'b01; selEAB1 = 0; selEAB2 = 2'b10; enaMARM = 1; selMAR = 1;
        sb_push(S_BUS, 0, 16'hFFFF, "eab_off9");
        tick();
        sb_push(S_PC, 0, 16'hFFFF, "branch_wrap");
        ldPC = 1; selPC = 2'b00;
        tick();
        sb_push(S_PC, 0, 16'h0000, "pc_inc_wrap");
        ldPC = 1; selPC = 2'b11; enaMARM = 1; selMAR = 1; selEAB2 = 2'b01;
        sb_push(S_BUS, 0, 16'hFFFE, "eab_off6");
        tick();
        sb_push(S_PC, 0, 16'h0000, "pc_hold");
        enaMARM = 1; selMAR = 1; selEAB1 = 1; SR1 = 3'd3; selEAB2 = 2'b11;
        sb_push(S_BUS, 0, 16'hFFFF, "eab_off11");
        tick();
        enaMARM = 1; selMAR = 0;
        sb_push(S_BUS, 0, 16'h00FE, "marmux_zext_fe");
        tick();

        // Store setup: R4=4000 and R5=5000 from memory
        enaPC = 1; ldMAR = 1; ldPC = 1;
        tick();
        sb_push(S_MAR, 0, 16'h0000, "st_mar0");
        sb_push(S_PC,  0, 16'h0001, "st_pc1");
        ldMDR = 1; selMDR = 1;
        tick();
        sb_push(S_MDR, 0, 16'h4000, "st_mdr4000");
        enaMDR = 1; regWE = 1; DR = 3'd4; ldIR = 1;
        tick();
        sb_push(S_NZP, 0, 16'h0001, "st_nzp_r4");
        sb_push(S_IR,  0, 16'h4000, "ir_4000");
        // IR[5]=0: ALU B comes from SR2
        enaALU = 1; SR1 = 3'd4; SR2 = 3'd3;
        sb_push(S_BUS, 0, 16'h4001, "add_sr2");
        tick();
        enaALU = 1; aluControl = 2'b01; SR1 = 3'd4; SR2 = 3'd4;
        sb_push(S_BUS, 0, 16'h4000, "and_sr2");
        tick();
        enaALU = 1; SR1 = 3'd3; SR2 = 3'd3;
        sb_push(S_BUS, 0, 16'h0002, "add_sr2_r3");
        tick();
        enaPC = 1; ldMAR = 1; ldPC = 1;
        tick();
        sb_push(S_MAR, 0, 16'h0001, "st_mar1");
        ldMDR = 1; selMDR = 1;
        tick();
        sb_push(S_MDR, 0, 16'h5000, "st_mdr5000");
        enaMDR = 1; regWE = 1; DR = 3'd5;
        tick();
        enaPC = 1; ldMAR = 1; ldPC = 1;
        tick();
        sb_push(S_MAR, 0, 16'h0002, "st_mar2");
        sb_push(S_PC,  0, 16'h0003, "st_pc3");
        ldMDR = 1; selMDR = 1;
        tick();
        sb_push(S_MDR, 0, 16'hABCD, "st_mdrabcd");
        enaALU = 1; aluControl = 2'b11; SR1 = 3'd4; ldMAR = 1;
        tick();
        sb_push(S_MAR, 0, 16'h4000, "st_mar4000");
        // Write cycle: MAR/MDR reload in the same cycle must not affect it
        memWE = 1; enaALU = 1; aluControl = 2'b11; SR1 = 3'd5;
        ldMAR = 1; ldMDR = 1; selMDR = 0;
        sb_push(S_BUS, 0, 16'h5000, "st_bus5000");
        sb_push(S_WE,  0, 16'h0001, "st_mem_we");
        tick();
        sb_push(S_MAR, 0, 16'h5000, "st_mar5000");
        sb_push(S_MDR, 0, 16'h5000, "st_mdr_after");
        sb_push(S_MEM, 16'h4000, 16'hABCD, "mem4000");
        sb_push(S_MEM, 16'h5000, 16'h2222, "mem5000_kept");
        sb_push(S_WE,  0, 16'h0000, "mem_we_low");

        // Same-cycle read of DR sees old value
        fetch(16'h0003, 16'h14A1);
        enaPC = 1; ldMAR = 1; ldPC = 1;
        tick();
        ldMDR = 1; selMDR = 1;
        tick();
        sb_push(S_MDR, 0, 16'h0007, "mdr0007");
        enaMDR = 1; regWE = 1; DR = 3'd2;
        tick();
        rd_reg(3'd2, 16'h0007);
        SR1 = 3'd2; DR = 3'd2; enaALU = 1; regWE = 1;
        sb_push(S_BUS, 0, 16'h0008, "add_same_cycle");
        tick();
        rd_reg(3'd2, 16'h0008);
        rd_reg(3'd3, 16'h0001);
        rd_reg(3'd4, 16'h4000);
        rd_reg(3'd5, 16'h5000);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            failures += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
